// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter that grants up to two result producers per cycle onto the register file write ports
module rf_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*5-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  write_en_0,
  output logic [4:0]            write_addr_0,
  output logic [31:0]           write_data_0,
  output logic                  write_en_1,
  output logic [4:0]            write_addr_1,
  output logic [31:0]           write_data_1
);
  logic [4:0]         addr_v [NUM_REQ];
  logic [31:0]        data_v [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               a_vld, b_vld;
  logic [PTR_W-1:0]   a_idx, b_idx, last_idx;
  logic [4:0]         a_addr, b_addr;
  logic [31:0]        a_data, b_data;
  logic [NUM_REQ-1:0] grant;
  logic               en0_q, en1_q;
  logic [4:0]         addr0_q, addr1_q;
  logic [31:0]        data0_q, data1_q;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_v[i] = req_addr[5*i +: 5];
    assign data_v[i] = req_data[32*i +: 32];
  end
  // Scan from rr_ptr: first valid takes port 0, next valid not colliding on a nonzero address takes port 1
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    a_vld  = 1'b0;
    b_vld  = 1'b0;
    a_idx  = '0;
    b_idx  = '0;
    a_addr = '0;
    b_addr = '0;
    a_data = '0;
    b_data = '0;
    grant  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      idx = PTR_W'(sum >= (PTR_W+1)'(NUM_REQ) ? sum - (PTR_W+1)'(NUM_REQ) : sum);
      if (req_valid[idx] && !a_vld) begin
        a_vld      = 1'b1;
        a_idx      = idx;
        a_addr     = addr_v[idx];
        a_data     = data_v[idx];
        grant[idx] = 1'b1;
      end else if (req_valid[idx] && !b_vld && !(addr_v[idx] == a_addr && a_addr != '0)) begin
        b_vld      = 1'b1;
        b_idx      = idx;
        b_addr     = addr_v[idx];
        b_data     = data_v[idx];
        grant[idx] = 1'b1;
      end
    end
    last_idx = b_vld ? b_idx : a_idx;
    rr_ptr_d = !a_vld ? rr_ptr_q : (last_idx == PTR_W'(NUM_REQ-1)) ? '0 : last_idx + PTR_W'(1);
  end
  assign req_ready = rstn ? grant : '0;
  // Register winners onto the write ports; an idle port drops its enable but keeps addr/data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      en0_q    <= 1'b0;
      en1_q    <= 1'b0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      en0_q    <= a_vld && a_addr != '0;
      en1_q    <= b_vld && b_addr != '0;
      if (a_vld) begin
        addr0_q <= a_addr;
        data0_q <= a_data;
      end
      if (b_vld) begin
        addr1_q <= b_addr;
        data1_q <= b_data;
      end
    end
  end
  assign write_en_0   = en0_q;
  assign write_addr_0 = addr0_q;
  assign write_data_0 = data0_q;
  assign write_en_1   = en1_q;
  assign write_addr_1 = addr1_q;
  assign write_data_1 = data1_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: randomized and directed checks of rf_wb_arbiter against a queue-free behavioural model
module tb_rf_wb_arbiter;
  localparam int N = 4;
  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*5-1:0] req_addr = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           write_en_0, write_en_1;
  logic [4:0]     write_addr_0, write_addr_1;
  logic [31:0]    write_data_0, write_data_1;
  int vectors = 0;
  int errors = 0;
  int m_ptr = 0;
  logic        e_en0 = 0, e_en1 = 0;
  logic [4:0]  e_a0 = 0, e_a1 = 0;
  logic [31:0] e_d0 = 0, e_d1 = 0;
  logic [N-1:0] last_ready = '0;

  rf_wb_arbiter #(.NUM_REQ(N), .PTR_W(2)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .write_en_0(write_en_0), .write_addr_0(write_addr_0), .write_data_0(write_data_0),
    .write_en_1(write_en_1), .write_addr_1(write_addr_1), .write_data_1(write_data_1)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ad(int i);
    return req_addr[5*i +: 5];
  endfunction

  function automatic logic [31:0] dt(int i);
    return req_data[32*i +: 32];
  endfunction

  task automatic set_req(int i, bit v, logic [4:0] a, logic [31:0] d);
    req_valid[i]      = v;
    req_addr[5*i +: 5] = a;
    req_data[32*i +: 32] = d;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    e_en0 = 0; e_en1 = 0; e_a0 = 0; e_a1 = 0; e_d0 = 0; e_d1 = 0;
    last_ready = '0;
  endtask

  // Reference: walk requesters in circular order from the pointer, pick two winners by the address rule
  task automatic model_scan(output int a, output int b);
    a = -1;
    b = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) begin
        if (a < 0) a = i;
        else if (b < 0 && !(ad(i) == ad(a) && ad(a) != 0)) b = i;
      end
    end
  endtask

  // One clock: check combinational grants, then the registered write ports after the edge
  task automatic cycle();
    int a, b;
    logic [N-1:0] er;
    logic [4:0] aa, ba;
    logic [31:0] adt, bdt;
    #1;
    model_scan(a, b);
    er = '0;
    aa = 0; ba = 0; adt = 0; bdt = 0;
    if (a >= 0) begin er[a] = 1'b1; aa = ad(a); adt = dt(a); end
    if (b >= 0) begin er[b] = 1'b1; ba = ad(b); bdt = dt(b); end
    vectors++;
    if (req_ready !== er) begin
      errors++;
      $display("FAIL ready: got %b expected %b (ptr %0d valid %b)", req_ready, er, m_ptr, req_valid);
    end
    @(posedge clk);
    #1;
    e_en0 = (a >= 0) && aa != 0;
    e_en1 = (b >= 0) && ba != 0;
    if (a >= 0) begin e_a0 = aa; e_d0 = adt; m_ptr = ((b >= 0 ? b : a) + 1) % N; end
    if (b >= 0) begin e_a1 = ba; e_d1 = bdt; end
    vectors++;
    if ({write_en_0, write_addr_0, write_data_0} !== {e_en0, e_a0, e_d0}) begin
      errors++;
      $display("FAIL port0: got en=%b a=%0d d=%h expected en=%b a=%0d d=%h",
               write_en_0, write_addr_0, write_data_0, e_en0, e_a0, e_d0);
    end
    vectors++;
    if ({write_en_1, write_addr_1, write_data_1} !== {e_en1, e_a1, e_d1}) begin
      errors++;
      $display("FAIL port1: got en=%b a=%0d d=%h expected en=%b a=%0d d=%h",
               write_en_1, write_addr_1, write_data_1, e_en1, e_a1, e_d1);
    end
    last_ready = er;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    req_valid = '0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(i + 1), 32'h100 + 32'(i));
    @(negedge clk);
    #1;
    vectors++;
    if (req_ready !== 4'b0000 || write_en_0 !== 1'b0 || write_en_1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b en0=%b en1=%b required 0000/0/0", req_ready, write_en_0, write_en_1);
    end
    @(negedge clk);
    model_reset();
    rstn = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0011) begin
      errors++;
      $display("FAIL reset_first_grant: ready=%b required 0011", req_ready);
    end
    cycle();
  endtask

  task automatic test_two_req();
    do_reset();
    req_valid = '0;
    set_req(1, 1, 5'd3, 32'hAAAA0001);
    set_req(2, 1, 5'd7, 32'h00005555);
    #1;
    vectors++;
    if (req_ready !== 4'b0110) begin
      errors++;
      $display("FAIL two_req_ready: ready=%b required 0110", req_ready);
    end
    cycle();
    vectors++;
    if (!(write_en_0 === 1'b1 && write_addr_0 === 5'd3 && write_data_0 === 32'hAAAA0001 &&
          write_en_1 === 1'b1 && write_addr_1 === 5'd7 && write_data_1 === 32'h5555)) begin
      errors++;
      $display("FAIL two_req_write: en0=%b a0=%0d d0=%h en1=%b a1=%0d d1=%h required 1/3/aaaa0001/1/7/5555",
               write_en_0, write_addr_0, write_data_0, write_en_1, write_addr_1, write_data_1);
    end
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(i + 10), $urandom);
    #1;
    vectors++;
    if (req_ready !== 4'b1001) begin
      errors++;
      $display("FAIL two_req_ptr: ready=%b required 1001 (pointer should be 3)", req_ready);
    end
    cycle();
  endtask

  task automatic test_conflict();
    do_reset();
    req_valid = '0;
    set_req(0, 1, 5'd5, 32'h11111111);
    set_req(1, 1, 5'd5, 32'h22222222);
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL conflict_ready0: ready=%b required 0001", req_ready);
    end
    cycle();
    vectors++;
    if (!(write_en_0 === 1'b1 && write_addr_0 === 5'd5 && write_data_0 === 32'h11111111 && write_en_1 === 1'b0)) begin
      errors++;
      $display("FAIL conflict_write: en0=%b a0=%0d d0=%h en1=%b required 1/5/11111111/0",
               write_en_0, write_addr_0, write_data_0, write_en_1);
    end
    req_valid[0] = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL conflict_ready1: ready=%b required 0010", req_ready);
    end
    cycle();
  endtask

  task automatic test_zero_dest();
    do_reset();
    req_valid = '0;
    set_req(2, 1, 5'd0, 32'hFFFFFFFF);
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL zero_ready: ready=%b required 0100", req_ready);
    end
    cycle();
    vectors++;
    if (write_en_0 !== 1'b0 || write_en_1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_write: en0=%b en1=%b required 0/0", write_en_0, write_en_1);
    end
  endtask

  task automatic test_saturation();
    int waits [N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, 1, 5'(i + 1), $urandom);
      waits[i] = 0;
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (req_ready !== ((c % 2 == 0) ? 4'b0011 : 4'b1100)) begin
        errors++;
        $display("FAIL sat_ready c%0d: ready=%b required %b", c, req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      end
      cycle();
      for (int i = 0; i < N; i++) begin
        if (last_ready[i]) begin
          waits[i] = 0;
          set_req(i, 1, 5'(i + 1), $urandom);
        end else waits[i]++;
        if (waits[i] > 2) begin
          errors++;
          $display("FAIL sat_starve req%0d: waited %0d cycles, limit 2", i, waits[i]);
        end
      end
    end
  endtask

  // Hold-until-ready requesters with frequent address collisions and r0 targets
  task automatic random_traffic(int cycles);
    for (int c = 0; c < cycles; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_ready[i])
          set_req(i, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
    random_traffic(300);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 5'($urandom_range(1, 7)), $urandom);
    random_traffic($urandom_range(3, 10));
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({req_ready, write_en_0, write_addr_0, write_data_0, write_en_1, write_addr_1, write_data_1} !== '0) begin
      errors++;
      $display("FAIL async_reset: ready=%b en0=%b a0=%0d d0=%h en1=%b a1=%0d d1=%h required all zero",
               req_ready, write_en_0, write_addr_0, write_data_0, write_en_1, write_addr_1, write_data_1);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(i + 20), $urandom);
    #1;
    vectors++;
    if (req_ready !== 4'b0011) begin
      errors++;
      $display("FAIL async_release: ready=%b required 0011", req_ready);
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_conflict();
    test_zero_dest();
    test_saturation();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
